// File: rtl/subleq_pkg.sv
// Shared definitions for the Subleq core: sequencer states and the halt address.
package subleq_pkg;

    // One state per memory transfer, plus the two parked states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_FETCH_C,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_HALT
    } state_t;

    // All-ones halt address, wide enough for any P_DATA up to 64;
    // users slice off the low P_DATA bits.
    localparam logic [63:0] HALT_ADDR = '1;

endpackage

// File: rtl/subleq_ctrl.sv
// Subleq sequencer: fetches A/B/C, reads mem[A] and mem[B], writes
// mem[B] - mem[A] back to B through the external ALU, then picks the next PC.
module subleq_ctrl
    import subleq_pkg::*;
#(
    parameter int P_DATA = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [P_DATA-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [P_DATA-1:0] mem_addr,
    output logic [P_DATA-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [P_DATA-1:0] mem_rdata,
    output logic [P_DATA-1:0] alu_a,
    output logic [P_DATA-1:0] alu_b,
    input  logic [P_DATA-1:0] alu_r,
    input  logic              alu_z
);

    localparam logic [P_DATA-1:0] HALT_PC = HALT_ADDR[P_DATA-1:0];

    state_t            state_q, state_d;
    logic [P_DATA-1:0] pc_q, a_q, b_q, c_q, va_q, vb_q, addr_q;
    logic              req_q, we_q;
    logic              xfer, to_halt;
    logic [P_DATA-1:0] pc_next;

    // A transfer completes whenever our registered request meets an ack.
    assign xfer    = req_q && mem_ack;
    assign to_halt = alu_z && (c_q == HALT_PC);
    assign pc_next = alu_z ? c_q : pc_q + P_DATA'(3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: every busy state advances only on a completed transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH_A;
            S_FETCH_A:      if (xfer)  state_d = S_FETCH_B;
            S_FETCH_B:      if (xfer)  state_d = S_FETCH_C;
            S_FETCH_C:      if (xfer)  state_d = S_READ_A;
            S_READ_A:       if (xfer)  state_d = S_READ_B;
            S_READ_B:       if (xfer)  state_d = S_EXEC;
            S_EXEC:         if (xfer)  state_d = to_halt ? S_HALT : S_FETCH_A;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Datapath and bus registers; the address for the next transfer is
    // loaded on the ack of the current one so it is stable while pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            va_q   <= '0;
            vb_q   <= '0;
            addr_q <= '0;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: if (start) begin
                    pc_q   <= '0;
                    addr_q <= '0;
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                end
                S_FETCH_A: if (xfer) begin
                    a_q    <= mem_rdata;
                    addr_q <= pc_q + P_DATA'(1);
                end
                S_FETCH_B: if (xfer) begin
                    b_q    <= mem_rdata;
                    addr_q <= pc_q + P_DATA'(2);
                end
                S_FETCH_C: if (xfer) begin
                    c_q    <= mem_rdata;
                    addr_q <= a_q;
                end
                S_READ_A: if (xfer) begin
                    va_q   <= mem_rdata;
                    addr_q <= b_q;
                end
                S_READ_B: if (xfer) begin
                    // Address already points at B; the write-back reuses it.
                    vb_q   <= mem_rdata;
                    we_q   <= 1'b1;
                end
                S_EXEC: if (xfer) begin
                    we_q   <= 1'b0;
                    pc_q   <= pc_next;
                    addr_q <= pc_next;
                    req_q  <= !to_halt;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    // ALU operands come straight from the operand registers, so the write
    // data is stable for the whole EXEC state.
    assign mem_wdata = (state_q == S_EXEC) ? alu_r : '0;
    assign alu_a     = vb_q;
    assign alu_b     = va_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: memory + ALU environment, instruction-level reference model.
module tb_subleq_ctrl;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } tx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mem_ack = 1'b0;
    logic       busy, halted, mem_req, mem_we, alu_z;
    logic [7:0] pc, mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_r;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    tx_t        txq[$];
    tx_t        exp_tx  [6];
    logic [7:0] ref_pc;
    bit         ref_halt;

    int         ack_mode = 0, hold_after = 0;
    int         wcnt = 0, tx_cnt = 0, wr_cnt = 0, stab_viol = 0;
    logic       pend = 1'b0;
    logic [16:0] pend_f = '0;
    int         checks = 0, errors = 0;

    subleq_ctrl #(.P_DATA(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .halted(halted), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign alu_r     = alu_a - alu_b;
    assign alu_z     = ($signed(alu_r) <= 8'sd0);

    // Memory model and bus monitor; while in reset the image is reloaded from ref_mem.
    always @(posedge clk) begin
        if (rst) begin
            mem = ref_mem;
            txq.delete();
            tx_cnt = 0; wr_cnt = 0; wcnt = 0; stab_viol = 0; pend = 1'b0;
        end else begin
            if (pend && mem_req && ({mem_we, mem_addr, mem_wdata} !== pend_f)) stab_viol++;
            pend   = mem_req && !mem_ack;
            pend_f = {mem_we, mem_addr, mem_wdata};
            if (mem_req && mem_ack) begin
                txq.push_back(tx_t'{we: mem_we, addr: mem_addr, data: mem_we ? mem_wdata : mem_rdata});
                tx_cnt++;
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_cnt++;
                end
            end else if (mem_req) wcnt++;
            else wcnt = 0;
        end
    end

    // Ack policy: 0 tied high, 1 two wait cycles per transfer, 2 random, 3 stop after hold_after transfers.
    always @(negedge clk) begin
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (wcnt >= 2);
            2:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = (tx_cnt < hold_after);
        endcase
    end

    // Reference: execute one Subleq instruction on ref_mem and list its bus transfers.
    task automatic ref_step();
        logic [7:0] a, b, c, r, p1, p2;
        p1 = ref_pc + 8'd1;
        p2 = ref_pc + 8'd2;
        a  = ref_mem[ref_pc];
        b  = ref_mem[p1];
        c  = ref_mem[p2];
        r  = ref_mem[b] - ref_mem[a];
        exp_tx[0] = tx_t'{we: 1'b0, addr: ref_pc, data: a};
        exp_tx[1] = tx_t'{we: 1'b0, addr: p1,     data: b};
        exp_tx[2] = tx_t'{we: 1'b0, addr: p2,     data: c};
        exp_tx[3] = tx_t'{we: 1'b0, addr: a,      data: ref_mem[a]};
        exp_tx[4] = tx_t'{we: 1'b0, addr: b,      data: ref_mem[b]};
        exp_tx[5] = tx_t'{we: 1'b1, addr: b,      data: r};
        ref_mem[b] = r;
        if ($signed(r) <= 8'sd0) begin
            ref_pc   = c;
            ref_halt = (c == 8'hFF);
        end else begin
            ref_pc = ref_pc + 8'd3;
        end
    endtask

    task automatic clear_ref();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        ref_pc   = 8'h00;
        ref_halt = 1'b0;
    endtask

    task automatic load_basic(input logic [7:0] m9);
        clear_ref();
        ref_mem[0] = 8'd9; ref_mem[1] = 8'd10; ref_mem[2] = 8'd6;
        ref_mem[9] = m9;   ref_mem[10] = 8'd5;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Count cycles after the start edge until n write-backs have completed.
    task automatic wait_writes(input int n, input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (wr_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, halted, mem_req, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, halted, mem_req, mem_we}); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if ({mem_addr, mem_wdata} !== 16'h0) begin errors++; $display("FAIL reset_bus: got %h want 0000", {mem_addr, mem_wdata}); end
        checks++; if ({alu_a, alu_b} !== 16'h0) begin errors++; $display("FAIL reset_alu: got %h want 0000", {alu_a, alu_b}); end
        release_reset();
        @(negedge clk);
        checks++; if ({busy, mem_req} !== 2'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 00", {busy, mem_req}); end
    endtask

    task automatic test_basic();
        int cyc; bit ok; tx_t got;
        rst = 1'b1; ack_mode = 0;
        load_basic(8'd2);
        release_reset();
        ref_step();
        @(negedge clk); start = 1'b1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL req_before_start: got %b want 0", mem_req); end
        @(negedge clk); start = 1'b0;
        checks++; if ({mem_req, busy, mem_we, mem_addr} !== {3'b110, 8'h00}) begin errors++; $display("FAIL req_rise: got %h want %h", {mem_req, busy, mem_we, mem_addr}, {3'b110, 8'h00}); end
        wait_writes(1, 40, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no write want 1"); end
        checks++; if (cyc != 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", cyc); end
        checks++; if (mem[10] !== 8'd3) begin errors++; $display("FAIL basic_result: got %h want 03", mem[10]); end
        checks++; if (pc !== 8'd3) begin errors++; $display("FAIL basic_pc: got %h want 03", pc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (txq.size() == 0) begin errors++; $display("FAIL basic_tx%0d: got none want %h", i, exp_tx[i]); end
            else begin got = txq.pop_front(); if (got !== exp_tx[i]) begin errors++; $display("FAIL basic_tx%0d: got %h want %h", i, got, exp_tx[i]); end end
        end
    endtask

    task automatic test_branch();
        int cyc; bit ok;
        rst = 1'b1; ack_mode = 0;
        load_basic(8'd5);
        release_reset();
        pulse_start();
        wait_writes(1, 40, cyc, ok);
        checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL branch_latency: got %0d want 6", cyc); end
        checks++; if (mem[10] !== 8'd0) begin errors++; $display("FAIL branch_result: got %h want 00", mem[10]); end
        checks++; if (pc !== 8'd6) begin errors++; $display("FAIL branch_pc: got %h want 06", pc); end
    endtask

    task automatic test_halt();
        int cyc, hi; bit ok;
        rst = 1'b1; ack_mode = 0;
        clear_ref();
        ref_mem[0] = 8'd9; ref_mem[1] = 8'd10; ref_mem[2] = 8'hFF;
        ref_mem[9] = 8'd7; ref_mem[10] = 8'd3;
        release_reset();
        ref_step();
        pulse_start();
        wait_writes(1, 40, cyc, ok);
        checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL halt_latency: got %0d want 6", cyc); end
        checks++; if ({halted, busy, mem_req} !== 3'b100) begin errors++; $display("FAIL halt_flags: got %b want 100", {halted, busy, mem_req}); end
        checks++; if (mem[10] !== 8'hFC) begin errors++; $display("FAIL halt_result: got %h want fc", mem[10]); end
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL halt_pc: got %h want ff", pc); end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_req || busy || !halted) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL halt_parked: got %0d active cycles want 0", hi); end
        // Restart from HALT re-runs from PC 0: 0xFC - 7 = 0xF5, halts again.
        ref_pc = 8'h00; ref_halt = 1'b0;
        ref_step();
        pulse_start();
        checks++; if ({halted, busy, pc} !== {2'b01, 8'h00}) begin errors++; $display("FAIL restart_state: got %h want %h", {halted, busy, pc}, {2'b01, 8'h00}); end
        wait_writes(2, 40, cyc, ok);
        checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL restart_latency: got %0d want 6", cyc); end
        checks++; if ({halted, mem[10]} !== {ref_halt, ref_mem[10]}) begin errors++; $display("FAIL restart_result: got %h want %h", {halted, mem[10]}, {ref_halt, ref_mem[10]}); end
    endtask

    task automatic test_wait_states();
        int cyc; bit ok; tx_t got;
        rst = 1'b1; ack_mode = 1;
        load_basic(8'd2);
        release_reset();
        ref_step();
        pulse_start();
        // A start pulse mid-instruction must be ignored.
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_writes(1, 80, cyc, ok);
        checks++; if (!ok || cyc + 4 != 18) begin errors++; $display("FAIL wait_latency: got %0d want 18", cyc + 4); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL wait_stable: got %0d changes want 0", stab_viol); end
        checks++; if ({mem[10], pc} !== {8'd3, 8'd3}) begin errors++; $display("FAIL wait_result: got %h want 0303", {mem[10], pc}); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (txq.size() == 0) begin errors++; $display("FAIL wait_tx%0d: got none want %h", i, exp_tx[i]); end
            else begin got = txq.pop_front(); if (got !== exp_tx[i]) begin errors++; $display("FAIL wait_tx%0d: got %h want %h", i, got, exp_tx[i]); end end
        end
        ack_mode = 0;
    endtask

    task automatic test_wrap_signed();
        int cyc; bit ok; tx_t got;
        rst = 1'b1; ack_mode = 0;
        clear_ref();
        // A = B (same address) forces a branch to 254.
        ref_mem[0]   = 8'd20; ref_mem[1] = 8'd20; ref_mem[2] = 8'd254; ref_mem[20] = 8'd9;
        ref_mem[254] = 8'd30; ref_mem[255] = 8'd31;
        ref_mem[30]  = 8'h01; ref_mem[31] = 8'h80;
        release_reset();
        ref_step();
        pulse_start();
        wait_writes(1, 40, cyc, ok);
        checks++; if (!ok || pc !== 8'd254) begin errors++; $display("FAIL wrap_branch_pc: got %h want fe", pc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (txq.size() == 0) begin errors++; $display("FAIL same_ab_tx%0d: got none want %h", i, exp_tx[i]); end
            else begin got = txq.pop_front(); if (got !== exp_tx[i]) begin errors++; $display("FAIL same_ab_tx%0d: got %h want %h", i, got, exp_tx[i]); end end
        end
        ref_step();
        wait_writes(2, 40, cyc, ok);
        checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL wrap_latency: got %0d want 6", cyc); end
        checks++; if (mem[31] !== 8'h7F) begin errors++; $display("FAIL wrap_result: got %h want 7f", mem[31]); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL wrap_pc: got %h want 01", pc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (txq.size() == 0) begin errors++; $display("FAIL wrap_tx%0d: got none want %h", i, exp_tx[i]); end
            else begin got = txq.pop_front(); if (got !== exp_tx[i]) begin errors++; $display("FAIL wrap_tx%0d: got %h want %h", i, got, exp_tx[i]); end end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, nd; bit ok;
        rst = 1'b1; ack_mode = 3; hold_after = 4;
        load_basic(8'd2);
        release_reset();
        pulse_start();
        repeat (5) @(negedge clk);
        // READ_B is now pending with ack held low; reset between edges.
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, halted, mem_req, mem_we} !== 4'b0) begin errors++; $display("FAIL async_abort_ctrl: got %b want 0000", {busy, halted, mem_req, mem_we}); end
        checks++; if ({pc, mem_addr, mem_wdata, alu_a, alu_b} !== 40'h0) begin errors++; $display("FAIL async_abort_regs: got %h want 0", {pc, mem_addr, mem_wdata, alu_a, alu_b}); end
        nd = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) nd++;
        checks++; if (nd != 0) begin errors++; $display("FAIL abort_mem: got %0d changed bytes want 0", nd); end
        @(posedge clk); #1;
        checks++; if ({busy, mem_req} !== 2'b0) begin errors++; $display("FAIL abort_hold: got %b want 00", {busy, mem_req}); end
        ack_mode = 0;
        release_reset();
        ref_step();
        pulse_start();
        wait_writes(1, 40, cyc, ok);
        checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL rerun_latency: got %0d want 6", cyc); end
        checks++; if ({mem[10], pc} !== {8'd3, 8'd3}) begin errors++; $display("FAIL rerun_result: got %h want 0303", {mem[10], pc}); end
    endtask

    task automatic test_random();
        int cyc, nd; bit ok; tx_t got;
        for (int t = 0; t < 4; t++) begin
            rst = 1'b1; ack_mode = 2;
            clear_ref();
            foreach (ref_mem[i]) ref_mem[i] = 8'($urandom);
            release_reset();
            pulse_start();
            for (int n = 0; n < 10; n++) begin
                ref_step();
                wait_writes(n + 1, 300, cyc, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got no write %0d want write", t, n); break; end
                for (int i = 0; i < 6; i++) begin
                    checks++;
                    if (txq.size() == 0) begin errors++; $display("FAIL rand%0d_tx%0d_%0d: got none want %h", t, n, i, exp_tx[i]); end
                    else begin got = txq.pop_front(); if (got !== exp_tx[i]) begin errors++; $display("FAIL rand%0d_tx%0d_%0d: got %h want %h", t, n, i, got, exp_tx[i]); end end
                end
                checks++; if ({halted, pc} !== {ref_halt, ref_pc}) begin errors++; $display("FAIL rand%0d_pc%0d: got %h want %h", t, n, {halted, pc}, {ref_halt, ref_pc}); end
                if (ref_halt) break;
            end
            nd = 0;
            for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) nd++;
            checks++; if (nd != 0) begin errors++; $display("FAIL rand%0d_mem: got %0d differing bytes want 0", t, nd); end
        end
        ack_mode = 0;
    endtask

    initial begin
        clear_ref();
        test_reset();
        test_basic();
        test_branch();
        test_halt();
        test_wait_states();
        test_wrap_signed();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Sequencer for the Subleq core: fetches each three-word instruction (A, B, C), reads both operands, drives the subtracting ALU, writes the result back and selects the next PC. It owns the single memory port and the ALU operand inputs. It sits between the unified memory and the ALU at core top level, and runs from `start` until a taken branch to the halt address.

## Interface
Parameters:
- `P_DATA`, default 8: data width; addresses are also `P_DATA` bits.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: one-cycle pulse; begins execution at PC 0 from IDLE or HALT.
- `busy`  out  1: high in every state except IDLE and HALT.
- `halted`  out  1: high in HALT.
- `pc`  out  P_DATA: current instruction address.
- `mem_req`  out  1: transfer request.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  P_DATA: transfer address.
- `mem_wdata`  out  P_DATA: write data.
- `mem_ack`  in  1: transfer completes in any cycle where `mem_req && mem_ack`.
- `mem_rdata`  in  P_DATA: read data, valid in the ack cycle.
- `alu_a`  out  P_DATA: minuend, the value of mem[B].
- `alu_b`  out  P_DATA: subtrahend, the value of mem[A].
- `alu_r`  in  P_DATA: a − b, two's complement wrap.
- `alu_z`  in  1: result ≤ 0 (signed).

## Operation
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, EXEC, HALT.
- IDLE/HALT → FETCH_A on `start`. This clears `pc` to 0 and clears `halted`. `start` is ignored in all other states.
- FETCH_A: read `pc`, latch A. FETCH_B: read `pc+1`, latch B. FETCH_C: read `pc+2`, latch C. All address additions wrap mod 2^P_DATA.
- READ_A: read addr A, latch `va`. READ_B: read addr B, latch `vb`.
- EXEC: write to addr B with `mem_wdata = alu_r`, where `alu_a = vb` and `alu_b = va`. On ack:
  - If `alu_z` and C = all-ones: go to HALT, `pc` ← C.
  - Else if `alu_z`: `pc` ← C, go to FETCH_A.
  - Else: `pc` ← `pc+3`, go to FETCH_A.
- Each state advances only on ack. The state is held for any number of wait cycles.
- Both operands are treated as signed; width rules come from the ALU. Overflow wraps silently.
- A = B is legal: READ_B rereads the same address.

## Timing
- Reset values:
  - State IDLE.
  - `pc`, A, B, C, `va`, `vb` = 0.
  - `mem_req`, `mem_we`, `busy`, `halted` = 0.
  - `mem_addr`, `mem_wdata`, `alu_a`, `alu_b` = 0.
- `mem_req` is registered. It rises the cycle after `start` is sampled and stays high across back-to-back transfers.
- `mem_addr`, `mem_we`, `mem_wdata` change only in the cycle after an ack; they are stable while a request is pending.
- `mem_req` drops the cycle after the EXEC ack that enters HALT. In IDLE and HALT it is 0.
- Latency with zero wait states (ack tied high): 6 cycles per instruction. Each memory wait cycle adds 1.
- `alu_a` and `alu_b` are driven from registers and are stable throughout EXEC. `alu_r` and `alu_z` are sampled only in the EXEC ack cycle.
- `rst` mid-transfer aborts immediately: `mem_req` deasserts asynchronously and no write-back or PC update occurs.

## Structure
- Shared package `subleq_pkg`: state enumeration and the `HALT_ADDR` constant (all-ones of `P_DATA`).
- No internal sub-module. The ALU is instantiated beside `subleq_ctrl` at core top level and connected through the `alu_*` ports.

## Test plan
- Basic instruction, P_DATA=8, ack tied high. mem[0..2]={9,10,6}, mem[9]=2, mem[10]=5; pulse `start` → mem[10]=3, `pc`=3 after 6 cycles; reads hit addresses 0,1,2,9,10, then a write to 10.
- Taken branch. Same program with mem[9]=5, mem[10]=5 → mem[10]=0, `alu_z`=1, `pc`=6.
- Halt. mem[0..2]={9,10,255}, mem[9]=7, mem[10]=3 → mem[10]=0xFC, `halted`=1, `busy`=0, `mem_req`=0 from cycle 7 onward.
- Wait states. Ack asserted 2 cycles after each req edge → instruction takes 18 cycles; address and data held stable while pending.
- Wrap and signed. `pc`=254 reached by a branch; fetch addresses are 254, 255, 0. mem[A]=1, mem[B]=0x80 → result 0x7F, no branch, `pc`=1.
- Reset during READ_B with ack held low → all outputs at reset values next edge, memory unchanged; a subsequent `start` re-executes from PC 0.
